// File: rtl/adc_capture_pkg.sv
// Shared types and constants for the ADC sample capture block.
package adc_capture_pkg;

    localparam int unsigned CHECKSUM_BITS = 32;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        CAPTURE = 2'd1,
        READOUT = 2'd2
    } capture_state_t;

endpackage

// File: rtl/simple_dual_port_ram.sv
// Sample buffer: one write port, one read port with a registered (1-cycle) read.
module simple_dual_port_ram #(
    parameter int unsigned DATA_WIDTH = 12,
    parameter int unsigned ADDR_WIDTH = 4
) (
    input  logic                  clk,
    input  logic                  i_wr_en,
    input  logic [ADDR_WIDTH-1:0] i_wr_addr,
    input  logic [DATA_WIDTH-1:0] i_wr_data,
    input  logic                  i_rd_en,
    input  logic [ADDR_WIDTH-1:0] i_rd_addr,
    output logic [DATA_WIDTH-1:0] o_rd_data
);

    localparam int unsigned DEPTH = 2 ** ADDR_WIDTH;

    logic [DATA_WIDTH-1:0] r_mem [DEPTH];
    logic [DATA_WIDTH-1:0] r_q;

    always_ff @(posedge clk) begin
        if (i_wr_en) begin
            r_mem[i_wr_addr] <= i_wr_data;
        end
        if (i_rd_en) begin
            r_q <= r_mem[i_rd_addr];
        end
    end

    assign o_rd_data = r_q;

endmodule

// File: rtl/adc_sample_capture.sv
// Captures a (optionally decimated) burst of ADC samples, then streams it out over valid/ready.
// Define ADC_CAPTURE_CHECKSUM_EN to build the running checksum of captured samples.
module adc_sample_capture
    import adc_capture_pkg::*;
#(
    parameter int unsigned SAMPLE_BITS = 12,
    parameter int unsigned NUM_SAMPLES = 16000,
    parameter int unsigned DECIM       = 1
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [SAMPLE_BITS-1:0]   sample_in,
    input  logic                     start,
    output logic                     busy,
    output logic                     done,
    output logic                     rd_valid,
    input  logic                     rd_ready,
    output logic [SAMPLE_BITS-1:0]   rd_data,
    output logic                     rd_last,
    output logic [CHECKSUM_BITS-1:0] checksum
);

    localparam int unsigned ADDR_W = $clog2(NUM_SAMPLES);
    localparam int unsigned DEC_W  = (DECIM > 1) ? $clog2(DECIM) : 1;
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(NUM_SAMPLES - 1);
    localparam logic [DEC_W-1:0]  LAST_DEC  = DEC_W'(DECIM - 1);

    capture_state_t         r_state;
    logic [ADDR_W-1:0]      r_wr_addr;
    logic [DEC_W-1:0]       r_dec_cnt;
    logic [ADDR_W-1:0]      r_rd_addr;
    logic                   r_rd_issued;
    logic                   r_busy;
    logic                   r_done;
    logic                   r_pend;
    logic                   r_pend_last;
    logic                   r_rd_valid;
    logic [SAMPLE_BITS-1:0] r_rd_data;
    logic                   r_rd_last;
    logic                   r_skid_valid;
    logic [SAMPLE_BITS-1:0] r_skid_data;
    logic                   r_skid_last;

    logic                   w_start_acc;
    logic                   w_wr_en;
    logic                   w_pop;
    logic                   w_room;
    logic                   w_rd_en;
    logic [SAMPLE_BITS-1:0] w_ram_q;

    assign w_start_acc = (r_state == IDLE) && start;
    assign w_wr_en     = (r_state == CAPTURE) && (r_dec_cnt == '0);
    assign w_pop       = r_rd_valid && rd_ready;
    // Output + skid give two slots; an in-flight read already owns one of them.
    assign w_room      = (2'(r_rd_valid) + 2'(r_skid_valid) + 2'(r_pend)) < (2'd2 + 2'(w_pop));
    assign w_rd_en     = (r_state == READOUT) && !r_rd_issued && w_room;

    simple_dual_port_ram #(
        .DATA_WIDTH (SAMPLE_BITS),
        .ADDR_WIDTH (ADDR_W)
    ) u_ram (
        .clk       (clk),
        .i_wr_en   (w_wr_en),
        .i_wr_addr (r_wr_addr),
        .i_wr_data (sample_in),
        .i_rd_en   (w_rd_en),
        .i_rd_addr (r_rd_addr),
        .o_rd_data (w_ram_q)
    );

    // Control FSM with address and decimation counters.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= IDLE;
            r_wr_addr   <= '0;
            r_dec_cnt   <= '0;
            r_rd_addr   <= '0;
            r_rd_issued <= 1'b0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (w_start_acc) begin
                        r_state     <= CAPTURE;
                        r_wr_addr   <= '0;
                        r_dec_cnt   <= '0;
                        r_rd_addr   <= '0;
                        r_rd_issued <= 1'b0;
                        r_busy      <= 1'b1;
                    end
                end
                CAPTURE: begin
                    r_dec_cnt <= (r_dec_cnt == LAST_DEC) ? '0 : r_dec_cnt + DEC_W'(1);
                    if (w_wr_en) begin
                        if (r_wr_addr == LAST_ADDR) begin
                            r_wr_addr <= '0;
                            r_state   <= READOUT;
                        end else begin
                            r_wr_addr <= r_wr_addr + ADDR_W'(1);
                        end
                    end
                end
                READOUT: begin
                    if (w_rd_en) begin
                        if (r_rd_addr == LAST_ADDR) begin
                            r_rd_addr   <= '0;
                            r_rd_issued <= 1'b1;
                        end else begin
                            r_rd_addr <= r_rd_addr + ADDR_W'(1);
                        end
                    end
                    if (w_pop && r_rd_last) begin
                        r_state <= IDLE;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    // Output register backed by a skid slot absorbing the RAM read latency.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pend       <= 1'b0;
            r_pend_last  <= 1'b0;
            r_rd_valid   <= 1'b0;
            r_rd_data    <= '0;
            r_rd_last    <= 1'b0;
            r_skid_valid <= 1'b0;
            r_skid_data  <= '0;
            r_skid_last  <= 1'b0;
        end else begin
            r_pend      <= w_rd_en;
            r_pend_last <= w_rd_en && (r_rd_addr == LAST_ADDR);
            if (w_pop || !r_rd_valid) begin
                if (r_skid_valid) begin
                    r_rd_valid   <= 1'b1;
                    r_rd_data    <= r_skid_data;
                    r_rd_last    <= r_skid_last;
                    r_skid_valid <= r_pend;
                    r_skid_data  <= w_ram_q;
                    r_skid_last  <= r_pend && r_pend_last;
                end else begin
                    r_rd_valid <= r_pend;
                    r_rd_last  <= r_pend && r_pend_last;
                    if (r_pend) begin
                        r_rd_data <= w_ram_q;
                    end
                end
            end else if (r_pend) begin
                r_skid_valid <= 1'b1;
                r_skid_data  <= w_ram_q;
                r_skid_last  <= r_pend_last;
            end
        end
    end

`ifdef ADC_CAPTURE_CHECKSUM_EN
    logic [CHECKSUM_BITS-1:0] r_checksum;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_checksum <= '0;
        end else if (w_start_acc) begin
            r_checksum <= '0;
        end else if (w_wr_en) begin
            r_checksum <= r_checksum + CHECKSUM_BITS'(sample_in);
        end
    end

    assign checksum = r_checksum;
`else
    assign checksum = '0;
`endif

    assign busy     = r_busy;
    assign done     = r_done;
    assign rd_valid = r_rd_valid;
    assign rd_data  = r_rd_data;
    assign rd_last  = r_rd_last;

endmodule

// File: tb/tb_adc_sample_capture.sv
// Directed bench for adc_sample_capture: two instances (DECIM=1 and DECIM=3, NUM_SAMPLES=8).
module tb_adc_sample_capture;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [11:0] sample_in = '0;
    logic        start    [2];
    logic        rd_ready [2];
    logic        busy     [2];
    logic        done     [2];
    logic        rd_valid [2];
    logic        rd_last  [2];
    logic [11:0] rd_data  [2];
    logic [31:0] checksum [2];

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    // Free-running counter doubles as the ADC stream.
    always @(posedge clk) sample_in <= sample_in + 12'd1;

    adc_sample_capture #(.SAMPLE_BITS(12), .NUM_SAMPLES(8), .DECIM(1)) u_dut_d1 (
        .clk(clk), .rst_n(rst_n), .sample_in(sample_in), .start(start[0]),
        .busy(busy[0]), .done(done[0]), .rd_valid(rd_valid[0]), .rd_ready(rd_ready[0]),
        .rd_data(rd_data[0]), .rd_last(rd_last[0]), .checksum(checksum[0])
    );

    adc_sample_capture #(.SAMPLE_BITS(12), .NUM_SAMPLES(8), .DECIM(3)) u_dut_d3 (
        .clk(clk), .rst_n(rst_n), .sample_in(sample_in), .start(start[1]),
        .busy(busy[1]), .done(done[1]), .rd_valid(rd_valid[1]), .rd_ready(rd_ready[1]),
        .rd_data(rd_data[1]), .rd_last(rd_last[1]), .checksum(checksum[1])
    );

    // One capture + readout on DUT d; data, rd_last, hold, done and checksum checked inline.
    task automatic run_burst(input int d, input int decim, input int mode, input bit extra,
                             input int want_base, input string name);
        logic [11:0] base, exp_v, prev_data;
        logic [31:0] exp_sum, exp_cs;
        int          idx, k, first_k, last_k, done_k;
        bit          prev_stall, rdy;
        idx = 0; first_k = -1; last_k = -1; done_k = -1;
        prev_stall = 1'b0; prev_data = '0; exp_sum = '0; k = 0;
        @(negedge clk);
        if (want_base >= 0) begin
            while (int'(sample_in) != want_base && k < 5000) begin
                @(negedge clk);
                k++;
            end
            checks++;
            if (int'(sample_in) != want_base) begin
                errors++;
                $display("FAIL %s base_wait: got %0d want %0d", name, sample_in, want_base);
            end
        end
        base = sample_in;
        start[d] = 1'b1;
        @(negedge clk);
        start[d] = 1'b0;
        checks++;
        if (busy[d] !== 1'b1) begin
            errors++;
            $display("FAIL %s busy_after_start: got %b want 1", name, busy[d]);
        end
        k = 0;
        while (done_k < 0 && k < 400) begin
            start[d] = extra && (k == 2 || k == 5 + 7 * decim);
            rdy = (mode == 0) ? 1'b1 : 1'($urandom_range(0, 1));
            rd_ready[d] = rdy;
            if (prev_stall) begin
                checks++;
                if (rd_valid[d] !== 1'b1 || rd_data[d] !== prev_data) begin
                    errors++;
                    $display("FAIL %s hold k=%0d: got valid=%b data=%0d want valid=1 data=%0d",
                             name, k, rd_valid[d], rd_data[d], prev_data);
                end
            end
            if (done[d] === 1'b1) begin
                done_k = k;
                checks++;
                if (idx != 8 || last_k != k - 1) begin
                    errors++;
                    $display("FAIL %s done_timing: got items=%0d last_hs=%0d done=%0d want items=8 done=last_hs+1",
                             name, idx, last_k, k);
                end
                checks++;
                if (busy[d] !== 1'b0) begin
                    errors++;
                    $display("FAIL %s busy_with_done: got %b want 0", name, busy[d]);
                end
            end else if (rd_valid[d] === 1'b1 && rdy) begin
                exp_v = base + 12'(1 + idx * decim);
                checks++;
                if (rd_data[d] !== exp_v) begin
                    errors++;
                    $display("FAIL %s data[%0d]: got %0d want %0d", name, idx, rd_data[d], exp_v);
                end
                checks++;
                if (rd_last[d] !== (idx == 7)) begin
                    errors++;
                    $display("FAIL %s last[%0d]: got %b want %b", name, idx, rd_last[d], idx == 7);
                end
                if (first_k < 0) first_k = k;
                last_k  = k;
                exp_sum = exp_sum + 32'(exp_v);
                idx++;
            end
            prev_stall = (rd_valid[d] === 1'b1) && !rdy;
            prev_data  = rd_data[d];
            @(negedge clk);
            k++;
        end
        start[d]    = 1'b0;
        rd_ready[d] = 1'b0;
        checks++;
        if (done_k < 0) begin
            errors++;
            $display("FAIL %s timeout: got no done in 400 cycles want done", name);
        end else begin
            if (done[d] !== 1'b0) begin
                errors++;
                $display("FAIL %s done_pulse_width: got %b want 0", name, done[d]);
            end
`ifdef ADC_CAPTURE_CHECKSUM_EN
            exp_cs = exp_sum;
`else
            exp_cs = '0;
`endif
            checks++;
            if (checksum[d] !== exp_cs) begin
                errors++;
                $display("FAIL %s checksum: got %0d want %0d", name, checksum[d], exp_cs);
            end
            if (mode == 0) begin
                checks++;
                if (done_k != 11 + 7 * decim) begin
                    errors++;
                    $display("FAIL %s done_latency: got %0d want %0d", name, done_k, 11 + 7 * decim);
                end
                checks++;
                if (last_k - first_k != 7) begin
                    errors++;
                    $display("FAIL %s no_bubbles: got span %0d want 7", name, last_k - first_k);
                end
            end
        end
    endtask

    task automatic test_reset();
        repeat (2) @(negedge clk);
        for (int d = 0; d < 2; d++) begin
            checks++;
            if ({busy[d], done[d], rd_valid[d], rd_last[d]} !== 4'b0 || rd_data[d] !== '0 || checksum[d] !== '0) begin
                errors++;
                $display("FAIL reset_outputs dut%0d: got busy=%b done=%b valid=%b last=%b data=%0d cs=%0d want all 0",
                         d, busy[d], done[d], rd_valid[d], rd_last[d], rd_data[d], checksum[d]);
            end
        end
        rst_n = 1'b1;
        @(negedge clk);
        for (int d = 0; d < 2; d++) begin
            checks++;
            if (busy[d] !== 1'b0 || rd_valid[d] !== 1'b0) begin
                errors++;
                $display("FAIL idle_after_reset dut%0d: got busy=%b valid=%b want 0 0", d, busy[d], rd_valid[d]);
            end
        end
    endtask

    task automatic test_basic();
        run_burst(0, 1, 0, 1'b0, 10, "basic_d1");
        checks++;
`ifdef ADC_CAPTURE_CHECKSUM_EN
        if (checksum[0] !== 32'd116) begin
            errors++;
            $display("FAIL basic_checksum116: got %0d want 116", checksum[0]);
        end
`else
        if (checksum[0] !== 32'd0) begin
            errors++;
            $display("FAIL basic_checksum_off: got %0d want 0", checksum[0]);
        end
`endif
    endtask

    task automatic test_decim();
        run_burst(1, 3, 0, 1'b0, -1, "decim3");
    endtask

    task automatic test_random_ready();
        run_burst(0, 1, 1, 1'b0, -1, "random_d1_a");
        run_burst(0, 1, 1, 1'b0, -1, "random_d1_b");
        run_burst(1, 3, 1, 1'b0, -1, "random_d3");
    endtask

    task automatic test_extra_starts();
        run_burst(0, 1, 0, 1'b1, -1, "extra_start_d1");
        run_burst(1, 3, 0, 1'b1, -1, "extra_start_d3");
    endtask

    task automatic test_back_to_back();
        int k;
        bit seen;
        rd_ready[0] = 1'b1;
        start[0]    = 1'b1;
        for (int pass = 0; pass < 2; pass++) begin
            seen = 1'b0;
            k    = 0;
            while (!seen && k < 200) begin
                @(negedge clk);
                k++;
                if (done[0] === 1'b1) seen = 1'b1;
            end
            checks++;
            if (!seen) begin
                errors++;
                $display("FAIL b2b_done pass%0d: got no done want done", pass);
            end
            if (pass == 0) begin
                @(negedge clk);
                checks++;
                if (busy[0] !== 1'b1 || done[0] !== 1'b0) begin
                    errors++;
                    $display("FAIL b2b_rearm: got busy=%b done=%b want busy=1 done=0", busy[0], done[0]);
                end
                start[0] = 1'b0;
            end
        end
        rd_ready[0] = 1'b0;
    endtask

    task automatic test_reset_mid();
        bit saw_done [2];
        @(negedge clk);
        start[0] = 1'b1; start[1] = 1'b1;
        rd_ready[0] = 1'b1; rd_ready[1] = 1'b1;
        @(negedge clk);
        start[0] = 1'b0; start[1] = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if (busy[0] !== 1'b1) begin
            errors++;
            $display("FAIL mid_capture_busy: got %b want 1", busy[0]);
        end
        rst_n = 1'b0;
        #1;
        for (int d = 0; d < 2; d++) begin
            checks++;
            if ({busy[d], done[d], rd_valid[d], rd_last[d]} !== 4'b0 || rd_data[d] !== '0 || checksum[d] !== '0) begin
                errors++;
                $display("FAIL midreset_outputs dut%0d: got busy=%b done=%b valid=%b last=%b data=%0d cs=%0d want all 0",
                         d, busy[d], done[d], rd_valid[d], rd_last[d], rd_data[d], checksum[d]);
            end
            saw_done[d] = 1'b0;
        end
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            if (c == 2) rst_n = 1'b1;
            for (int d = 0; d < 2; d++) if (done[d] !== 1'b0 || busy[d] !== 1'b0) saw_done[d] = 1'b1;
        end
        for (int d = 0; d < 2; d++) begin
            checks++;
            if (saw_done[d]) begin
                errors++;
                $display("FAIL midreset_quiet dut%0d: got done/busy activity want none", d);
            end
        end
        rd_ready[0] = 1'b0; rd_ready[1] = 1'b0;
        run_burst(0, 1, 0, 1'b0, -1, "post_reset_d1");
        run_burst(1, 3, 0, 1'b0, -1, "post_reset_d3");
    endtask

    initial begin
        rst_n = 1'b0;
        start[0] = 1'b0; start[1] = 1'b0;
        rd_ready[0] = 1'b0; rd_ready[1] = 1'b0;
        test_reset();
        test_basic();
        test_decim();
        test_random_ready();
        test_extra_starts();
        test_back_to_back();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: got no finish by 400000 want finish");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/adc_sample_capture.md
Name: adc_sample_capture

Overview:
- Sink-side counterpart to the simulation ADC source. Captures a fixed-length burst of ADC samples into an on-chip buffer, optionally decimated.
- After capture, streams the buffer out over a valid/ready interface.
- Sits between the ADC output (real or dummy) and downstream feature-extraction or host-readout logic. Synthesizable; also used in benches to record ADC streams.

Parameters:
- SAMPLE_BITS, 12, width of sample_in and rd_data.
- NUM_SAMPLES, 16000, samples per capture burst. Must be >= 2; need not be a power of two.
- DECIM, 1, capture one sample every DECIM cycles. Must be >= 1.

Ports:
- clk  input  1  system clock, all logic on posedge.
- rst_n  input  1  asynchronous active-low reset.
- sample_in  input  SAMPLE_BITS  ADC sample, new value assumed every cycle.
- start  input  1  capture request, honoured only in IDLE.
- busy  output  1  high from start acceptance until the final readout handshake.
- done  output  1  single-cycle pulse after the final readout handshake.
- rd_valid  output  1  rd_data holds a buffered sample.
- rd_ready  input  1  consumer accepts rd_data.
- rd_data  output  SAMPLE_BITS  buffered sample, oldest first.
- rd_last  output  1  qualifies the sample at index NUM_SAMPLES-1.
- checksum  output  32  sum of captured samples (see Optional Feature).

Behaviour:
- Reset values: busy=0, done=0, rd_valid=0, rd_last=0, rd_data=0, checksum=0. All counters cleared, FSM in IDLE. Buffer contents undefined after reset.
- States:
  - IDLE: start=1 at edge N moves to CAPTURE; busy=1 from N+1.
  - CAPTURE: decimation counter cleared on entry. sample_in is written at edges N+1, N+1+DECIM, …, N+1+(NUM_SAMPLES-1)*DECIM. Write address runs 0..NUM_SAMPLES-1. After the last write, go to READOUT.
  - READOUT: read address runs 0..NUM_SAMPLES-1 through a registered-read RAM (1-cycle latency). First rd_valid no later than 2 cycles after the last write. The final handshake moves to IDLE.
- Handshake:
  - Transfer occurs when rd_valid && rd_ready.
  - While rd_valid && !rd_ready, rd_data and rd_last are held stable.
  - With rd_ready held high, throughput is one sample per cycle and there are no bubbles. This requires a prefetch/skid register over the RAM latency.
- rd_last: high only with the sample at index NUM_SAMPLES-1.
- done: pulses on the cycle after the final handshake. busy=0 on that same cycle.
- start outside IDLE is ignored, with no effect on counters. start held high in IDLE re-arms on the cycle after done.
- Address counters use width $clog2(NUM_SAMPLES). Wrap is explicit at NUM_SAMPLES-1 and does not rely on overflow.
- rst_n assertion mid-capture or mid-readout immediately returns to IDLE with all outputs at reset values. No done pulse is generated.

Optional Feature:
- Macro: ADC_CAPTURE_CHECKSUM_EN.
- Enabled:
  - checksum is cleared on start acceptance.
  - Each written sample is added, zero-extended, modulo 2^32.
  - The value is stable from the cycle after the last write until the next start acceptance.
- Disabled: checksum is tied to 0 and no adder is synthesized.

Decomposition:
- Package adc_capture_pkg:
  - capture_state_t enum (IDLE, CAPTURE, READOUT).
  - CHECKSUM_BITS = 32 constant.
- Sub-module simple_dual_port_ram: one write port, one registered read port. Parameters DATA_WIDTH and ADDR_WIDTH; the RAM depth is 2**ADDR_WIDTH.
- The FSM, counters and skid logic stay in adc_sample_capture.

Test Plan:
- NUM_SAMPLES=8, DECIM=1, sample_in=free-running cycle count, start pulsed at cycle 10 -> readout 11..18. rd_last on 18. done one cycle after the last handshake. Checksum 116 when the macro is defined.
- NUM_SAMPLES=8, DECIM=3, same stimulus -> readout 11,14,17,20,23,26,29,32.
- rd_ready pseudo-random (~50%) -> every value delivered exactly once, in order. rd_data never changes while valid && !ready.
- rd_ready held high -> 8 consecutive cycles with rd_valid=1 (no bubbles).
- start pulsed during CAPTURE and during READOUT -> no effect: identical data, and done timing matches the single-start run.
- rst_n low at the 4th capture write -> all outputs 0 immediately, no done pulse. A subsequent start gives a clean 8-sample burst.
